// File: rtl/trig_capture_pkg.sv
// Shared types for the trigger/capture stage.
//   state_t   : capture FSM states
//   EDGE_RISE : trig_edge value selecting a rising crossing
//   EDGE_FALL : trig_edge value selecting a falling crossing
package trig_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    READ
  } state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/trig_capture_ram.sv
// Simple dual-port sample buffer, DEPTH x DATA_W.
//   clk, rst          : clock; rst clears only the read-data register
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read port, data appears on rdata_o one cycle later
//   rdata_o           : registered read data, held while re_i is low
module trig_capture_ram
  import trig_capture_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register doubles as the output stage of the stream, so it is
  // reset and holds its value whenever no new read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trig_capture.sv
// Scope-style trigger and capture stage.
// Compares the ADC stream against a latched level, detects the selected
// crossing, stores PRE_TRIG samples before and DEPTH-PRE_TRIG samples from
// the trigger on, then streams the window oldest-first over valid/ready.
//   clk, rst                : clock, async active-high reset
//   adc_valid, adc_data     : input sample stream
//   trig_level, trig_edge   : threshold and edge select, latched on arm
//   arm, abort              : start capture (IDLE only) / return to IDLE
//   busy, triggered         : status
//   rd_valid, rd_ready, rd_data, rd_last : readout stream
//   done                    : pulse after the last beat is accepted
module trig_capture
  import trig_capture_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              arm,
  input  logic              abort,
  output logic              busy,
  output logic              triggered,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  PRE_LAST    = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST   = CNT_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  BEATS       = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS     = ADDR_W'(PRE_TRIG);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              edge_sel_q, edge_sel_d;
  logic              prev_ok_q, prev_ok_d;
  logic              triggered_q, triggered_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              done_q, done_d;
  logic              wr_en, rd_en, hit, beat;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      level_q     <= '0;
      prev_q      <= '0;
      edge_sel_q  <= EDGE_RISE;
      prev_ok_q   <= 1'b0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      level_q     <= level_d;
      prev_q      <= prev_d;
      edge_sel_q  <= edge_sel_d;
      prev_ok_q   <= prev_ok_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rd_cnt_d    = rd_cnt_q;
    level_d     = level_q;
    prev_d      = prev_q;
    edge_sel_d  = edge_sel_q;
    prev_ok_d   = prev_ok_q;
    triggered_d = triggered_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    hit         = 1'b0;
    beat        = rd_valid_q && rd_ready;

    if (edge_sel_q == EDGE_RISE) hit = (prev_q <  level_q) && (adc_data >= level_q);
    else                         hit = (prev_q >= level_q) && (adc_data <  level_q);
    hit = hit && prev_ok_q && adc_valid;

    if (adc_valid && (state_q inside {PRE, WAIT, POST})) begin
      wr_en     = 1'b1;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      prev_d    = adc_data;
      prev_ok_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = PRE;
          level_d     = trig_level;
          edge_sel_d  = trig_edge;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          rd_cnt_d    = '0;
          prev_ok_d   = 1'b0;
          triggered_d = 1'b0;
        end
      end
      PRE: begin
        if (adc_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PRE_LAST) state_d = WAIT;
        end
      end
      WAIT: begin
        // The readout start is fixed here, when the trigger address is known.
        if (hit) begin
          triggered_d = 1'b1;
          rd_ptr_d    = wr_ptr_q - PRE_OFS;
          cnt_d       = CNT_W'(1);
          state_d     = (POST_LAST == '0) ? READ : POST;
        end
      end
      POST: begin
        if (adc_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == POST_LAST) state_d = READ;
        end
      end
      READ: begin
        // A new read is issued only when the output register is empty or
        // being drained, so the RAM read register itself is the skid stage.
        if ((rd_cnt_q != BEATS) && (!rd_valid_q || rd_ready)) begin
          rd_en      = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
          rd_last_d  = (rd_cnt_q == LAST_BEAT);
          rd_valid_d = 1'b1;
        end else if (beat) begin
          rd_valid_d = 1'b0;
        end
        if (beat && rd_last_q) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          triggered_d = 1'b0;
          rd_valid_d  = 1'b0;
          rd_last_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      triggered_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      done_d      = 1'b0;
      rd_en       = 1'b0;
    end
  end

  trig_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (adc_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign busy      = (state_q != IDLE);
  assign triggered = triggered_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = ram_rdata;
  assign rd_last   = rd_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trig_capture.sv
module tb_trig_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int NCYC  = 400;
  localparam int LIMIT = NCYC + 200;

  logic          clk = 1'b0;
  logic          rst, adc_valid, trig_edge, arm, abort, rd_ready;
  logic [DW-1:0] adc_data, trig_level, rd_data;
  logic          busy, triggered, rd_valid, rd_last, done;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sd [NCYC];
  logic          sv [NCYC];
  logic [DW-1:0] exp_win [DEPTH];
  int            trig_cyc;
  bit            found;
  logic [6:0]    rdy_pat = 7'b1001101;  // 1,0,1,1,0,0,1 from bit 0 up

  always #5 clk = ~clk;

  trig_capture #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .PRE_TRIG (PRE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .arm        (arm),
    .abort      (abort),
    .busy       (busy),
    .triggered  (triggered),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit crosses(input logic [DW-1:0] p, input logic [DW-1:0] c,
                                 input logic [DW-1:0] lvl, input logic e);
    if (!e) return (p <  lvl) && (c >= lvl);
    else    return (p >= lvl) && (c <  lvl);
  endfunction

  // Reference: list the accepted samples, find the first crossing whose
  // current sample comes after the first PRE samples, and take the window
  // PRE samples before it through DEPTH-PRE-1 samples after it.
  task automatic build_model(input logic [DW-1:0] lvl, input logic e);
    int vi[$];
    found    = 1'b0;
    trig_cyc = -1;
    for (int c = 0; c < NCYC; c++) if (sv[c]) vi.push_back(c);
    for (int k = PRE; k + DEPTH - PRE - 1 < vi.size() && !found; k++) begin
      if (crosses(sd[vi[k-1]], sd[vi[k]], lvl, e)) begin
        found    = 1'b1;
        trig_cyc = vi[k];
        for (int j = 0; j < DEPTH; j++) exp_win[j] = sd[vi[k-PRE+j]];
      end
    end
  endtask

  // kind 0 = ramp up, 1 = ramp down, 2 = random; pv = percent of valid cycles
  task automatic gen(input int kind, input logic [DW-1:0] start, input int pv);
    logic [DW-1:0] v;
    v = start;
    for (int c = 0; c < NCYC; c++) begin
      sv[c] = ($urandom_range(99) < pv);
      sd[c] = 8'($urandom);
      if (sv[c] && kind != 2) begin
        sd[c] = v;
        v = (kind == 0) ? v + 8'd1 : v - 8'd1;
      end
    end
  endtask

  // mode 0 = full capture, 1 = abort in READ, 2 = reset in READ,
  // 3 = expect no trigger then abort in WAIT
  // rmode 0 = always ready, 1 = fixed pattern, 2 = random ready
  task automatic capture(input logic [DW-1:0] lvl, input logic e, input logic [DW-1:0] distract,
                         input int mode, input int rmode);
    int beats, dones, last_c, quiet, tail;
    bit stall_prev, stopped, fin;
    logic [DW-1:0] held_d;
    logic held_l;
    beats = 0; dones = 0; last_c = -10; quiet = 0; tail = 0;
    stall_prev = 0; stopped = 0; fin = 0; held_d = '0; held_l = 1'b0;
    build_model(lvl, e);
    trig_level = lvl; trig_edge = e; arm = 1'b1; adc_valid = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    @(posedge clk); #1;
    arm = 1'b0; trig_level = distract; trig_edge = ~e;
    chk("busy_after_arm", busy, 1);
    for (int c = 0; c < LIMIT && !fin; c++) begin
      adc_valid = (c < NCYC) ? sv[c] : 1'b1;
      adc_data  = (c < NCYC) ? sd[c] : 8'($urandom);
      case (rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = rdy_pat[c % 7];
        default: rd_ready = 1'($urandom_range(1));
      endcase
      abort = 1'b0;
      arm = !stopped && ((found && (c == trig_cyc - 1 || c == trig_cyc + 1)) ||
                         (rd_valid && $urandom_range(7) == 0));
      if (found && c == trig_cyc)     chk("trig_before", triggered, 0);
      if (found && c == trig_cyc + 1) chk("trig_after", triggered, 1);
      if (stopped) begin
        quiet++;
        chk("quiet_busy", busy, 0);
        chk("quiet_valid", rd_valid, 0);
        chk("quiet_done", done, 0);
        if (quiet == 1) chk("quiet_trig", triggered, 0);
        if (quiet >= 20) fin = 1;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", rd_valid, 1);
          chk("hold_data", rd_data, held_d);
          chk("hold_last", rd_last, held_l);
        end
        if (done) begin
          dones++;
          chk("done_timing", c, last_c + 1);
          chk("idle_after_done", busy, 0);
        end
        if (dones > 0) begin
          tail++;
          if (tail > 3) fin = 1;
        end
        if (rd_valid && rd_ready) begin
          if (beats < DEPTH) chk("beat_data", rd_data, exp_win[beats]);
          chk("beat_last", rd_last, beats == DEPTH - 1);
          if (rd_last) last_c = c;
          beats++;
        end
        stall_prev = rd_valid && !rd_ready;
        held_d = rd_data;
        held_l = rd_last;
        if (mode == 1 && beats == 3) begin
          abort = 1'b1;
          stopped = 1;
        end
        if (mode == 3 && c == NCYC - 1) begin
          chk("nofire_busy", busy, 1);
          chk("nofire_trig", triggered, 0);
          chk("nofire_valid", rd_valid, 0);
          abort = 1'b1;
          stopped = 1;
        end
        if (mode == 2 && beats == 3) begin
          rst = 1'b1;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_valid", rd_valid, 0);
          chk("rst_trig", triggered, 0);
          chk("rst_done", done, 0);
          stopped = 1;
        end
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
    if (mode == 0) begin
      chk("beat_count", beats, DEPTH);
      chk("done_count", dones, 1);
    end
    chk("finished", fin, 1);
    arm = 1'b0; abort = 1'b0; adc_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; adc_valid = 1'b0; adc_data = '0;
    trig_level = 8'd128; trig_edge = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_trig", triggered, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_last", rd_last, 0);
    chk("reset_done", done, 0);
    chk("reset_data", rd_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    gen(0, 8'd0, 100);   capture(8'd128, 1'b0, 8'd128, 0, 0);
    gen(0, 8'd0, 100);   capture(8'd128, 1'b0, 8'd128, 2, 0);
    gen(0, 8'd0, 100);   capture(8'd128, 1'b0, 8'd128, 0, 1);
    gen(1, 8'd255, 100); capture(8'd100, 1'b1, 8'd100, 0, 2);
    gen(2, 8'd0, 100);   capture(8'd0,   1'b0, 8'd0,   3, 2);
    gen(0, 8'd0, 100);   capture(8'd128, 1'b0, 8'd10,  0, 0);
    gen(0, 8'd126, 100); capture(8'd128, 1'b0, 8'd128, 0, 2);
    gen(0, 8'd0, 70);    capture(8'd50,  1'b0, 8'd50,  0, 1);
    gen(2, 8'd0, 100);   capture(8'd200, 1'b1, 8'd3,   1, 0);
    for (int r = 0; r < 4; r++) begin
      gen(2, 8'd0, 60 + 10 * r);
      capture(8'($urandom_range(240, 16)), 1'($urandom_range(1)), 8'($urandom), 0, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
